// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for chunked_serial_adder.
//   - state_t      : controller states (IDLE, RUN, DONE)
//   - nchunk()     : number of CHUNK-wide slices in a WIDTH-wide operand
//   - idx_width()  : chunk-index register width, $clog2(NCHUNK) but never 0
//   - DEF_IDX_W    : index width for the default 16/4 configuration
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk adder still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(nchunk(16, 4));

endpackage

// File: rtl/ripple_slice.sv
// ripple_slice: CHUNK-bit combinational ripple-carry adder.
// Ports:
//   x, y : CHUNK-bit addends
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out of the top bit
module ripple_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic w_c;

  always_comb begin
    w_c = ci;
    s   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ w_c;
      w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit adder that processes CHUNK bits
// per clock through one shared ripple_slice.
// Optional feature macro: ADDER_SUB_EN (adds the op port; op=1 computes a-b).
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin           : operands and carry-in
//   op                  : 0 add, 1 subtract (ADDER_SUB_EN builds only)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout           : result and carry out of bit WIDTH-1
//   busy                : high in RUN or DONE
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCH   = nchunk(WIDTH, CHUNK);
  localparam int IDX_W = idx_width(NCH);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic [CHUNK-1:0]   w_s;
  logic               w_co;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_c_in;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_idx == IDX_W'(NCH - 1));

  // Subtraction is a + ~b + 1: invert b and force the carry-in on acceptance.
`ifdef ADDER_SUB_EN
  assign w_b_in = op ? ~b : b;
  assign w_c_in = op ? 1'b1 : cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  ripple_slice #(.CHUNK(CHUNK)) u_slice (
    .x  (r_a[r_idx*CHUNK +: CHUNK]),
    .y  (r_b[r_idx*CHUNK +: CHUNK]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)      w_next = RUN;
      RUN:     if (w_last)        w_next = DONE;
      DONE:    if (out_ready)     w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_c_in;
      r_sum   <= '0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
      r_carry                     <= w_co;
      r_idx                       <= r_idx + 1'b1;
      if (w_last) r_cout <= w_co;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Parametrised multi-cycle adder that sums two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through one reusable ripple-carry slice. Operands enter and results leave on valid/ready handshakes. The block is the area-saving successor to the fixed 4-bit combinational ripple adder, for datapaths where a wide add may take several cycles. It sits between an operand producer and a result consumer on the same clock.

## Interface
Parameters:
- WIDTH, 16, operand and sum width; must be a positive multiple of CHUNK, otherwise elaboration error.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- op  in  1  0 = add, 1 = subtract; present only with ADDER_SUB_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

## Operation
- NCHUNK = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch a, b and cin, clear chunk index and sum register, go to RUN.
- RUN: each cycle the slice adds a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry register. Write the result into sum[idx*CHUNK +: CHUNK] and the slice carry into the carry register, then increment idx. After slice NCHUNK-1, cout takes the final carry and the state goes to DONE.
- DONE: out_valid=1. sum and cout stay stable until out_valid && out_ready, then go to IDLE.
- in_ready is high only in IDLE. in_valid in RUN or DONE is ignored; the operands are not queued.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry of a+b+cin.
- sum bits not yet computed read 0 during RUN. sum is only meaningful while out_valid=1.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, idx=0, carry register=0.
- Acceptance edge at cycle T: out_valid rises after the edge at T+NCHUNK, i.e. NCHUNK cycles of RUN.
- out_ready high on the first DONE cycle: in_ready returns the next cycle. The minimum issue interval is NCHUNK+2 cycles.
- out_ready low: DONE is held indefinitely with sum and cout stable.
- rst_n asserted mid-RUN or mid-DONE: immediate return to reset values. The in-flight result is discarded and never presented.
- CHUNK == WIDTH: one RUN cycle, giving a latency of 1.

## Configuration
- ADDER_SUB_EN defined:
  - The op port exists.
  - On acceptance with op=1, the block latches ~b and forces carry-in to 1, so it computes a-b and cin is ignored.
  - cout=1 means no borrow.
  - op=0 behaves exactly as the add-only build.
- ADDER_SUB_EN undefined: the op port and its logic are absent, and the block only adds.

## Structure
- Shared package adder_pkg:
  - state enum (IDLE, RUN, DONE);
  - function computing NCHUNK;
  - localparam for the index width, $clog2(NCHUNK) with a minimum of 1.
- Sub-module ripple_slice: CHUNK-bit combinational ripple-carry adder with ports (x, y, ci, s, co). Instantiated once and reused every RUN cycle.
- The top level holds the FSM, the operand registers, the chunk index, the carry register and the sum register.

## Test plan
- WIDTH=4, CHUNK=1: a=4'b1101, b=4'b1001, cin=0 → after 4 RUN cycles out_valid=1, sum=4'b0110, cout=1.
- WIDTH=16, CHUNK=4: a=16'hFFFF, b=16'h0001, cin=0 → out_valid 4 cycles after acceptance, sum=16'h0000, cout=1. With cin=1 instead: sum=16'h0001, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum and cout stable, in_ready=0 throughout. Raise out_ready → in_ready=1 on the next cycle.
- in_valid pulsed with a=16'h1234 during RUN of a prior 16'h0001+16'h0002 → result is 16'h0003; the 16'h1234 is never accepted.
- Reset mid-op: assert rst_n=0 at RUN cycle 2 → outputs at reset values immediately, and no out_valid follows after release.
- ADDER_SUB_EN, WIDTH=16, CHUNK=4: op=1, a=16'h0005, b=16'h0007 → sum=16'hFFFE, cout=0. op=1, a=16'h0007, b=16'h0005 → sum=16'h0002, cout=1.
